fp_convert_scheduler: RTL

Shares one pipelined int-to-float converter instance (fixed latency, clk_en-gated) among NUM_REQ effect-path requesters.
- Arbitrates at most one issue per cycle and drives the converter's dataa/clk_en.
- Tracks requester tags through a shift pipeline matched to converter latency.
- Routes each result back with a one-cycle per-requester valid pulse.
- Sits between the effect datapaths and the converter wrapper on the DE1 audio clock domain.

---
 rtl/fp_convert_scheduler.sv | 110 +++++++++++
 1 files changed

// File: rtl/fp_convert_scheduler.sv
// rtl/fp_convert_scheduler.sv - shares one pipelined int-to-float converter among NUM_REQ requesters
// Optional build macro: FP_SCHED_FIXED_PRIO_EN (fixed lowest-index priority instead of round-robin).
module fp_convert_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic [DATA_W-1:0]         cvt_dataa,
  output logic                      cvt_clk_en,
  input  logic [DATA_W-1:0]         cvt_result,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic               issue;
  logic [IDX_W-1:0]   grant_idx;
  logic [LATENCY-1:0] stage_valid;
  logic [IDX_W-1:0]   stage_idx [LATENCY];

`ifdef FP_SCHED_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last (winning) assignment.
  always_comb begin
    issue     = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        issue     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    if (reset) begin
      issue = 1'b0;
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Descending offset scan: the smallest offset from the pointer wins.
  always_comb begin
    int cand;
    cand      = 0;
    issue     = 1'b0;
    grant_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[cand]) begin
        issue     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (reset) begin
      issue = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`endif

  always_comb begin
    gnt = '0;
    if (issue) begin
      gnt[grant_idx] = 1'b1;
    end
  end

  assign cvt_dataa  = issue ? req_data[int'(grant_idx)*DATA_W +: DATA_W] : '0;
  assign busy       = (|stage_valid) & ~reset;
  assign cvt_clk_en = issue | busy;

  // Tags move in lockstep with the converter, so stale converter contents never carry a valid tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_idx[i] <= '0;
      end
    end else if (cvt_clk_en) begin
      stage_valid[0] <= issue;
      stage_idx[0]   <= grant_idx;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_idx[i]   <= stage_idx[i-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (cvt_clk_en && stage_valid[LATENCY-1]) begin
      resp_valid[stage_idx[LATENCY-1]] = 1'b1;
    end
  end

  assign resp_data = (|resp_valid) ? cvt_result : '0;

endmodule
